gamepad_spi_tx: RTL and testbench
=================================

# gamepad_spi_tx

SPI master that serializes a 12-bit gamepad button word into the same 24-bit frame format that the ESP32 link delivers to the gamepad state block. It lets one board forward its selected `pad_btn` state to another board's gamepad SPI input. It also serves as a cycle-accurate stimulus source when benching the SPI gamepad receive path. It sits beside the gamepad source mux in the `clk` domain and drives three output pins.

## Interface

Parameters:
- `CLK_DIV`, default 4: `spi_clk` half-period in `clk` cycles; legal values are 1..255.
- `CSN_IDLE`, default 8: minimum `clk` cycles that `spi_csn` stays high between frames; legal values are 1..255.
- `PAD_INDEX`, default 0: 4-bit pad number placed in the frame header.

Ports:
- `clk` input, 1: system clock; this block uses a single clock.
- `reset` input, 1: reset is synchronous and active-high.
- `pad_btn` input, 12: button state to transmit; sampled only when a frame is accepted.
- `send` input, 1: request a frame; valid/ready style.
- `ready` output, 1: high only in IDLE, meaning a request will be accepted this cycle.
- `done` output, 1: one-cycle pulse at frame end.
- `spi_csn` output, 1: chip select, active low.
- `spi_clk` output, 1: SPI mode 0 clock, idles low.
- `spi_mosi` output, 1: serial data, MSB first.

## Operation

- Frame, 24 bits, MSB first: `{4'hA, PAD_INDEX[3:0], 4'h0, pad_btn[11:0]}`.
- Accept condition: `send && ready`. On the accepting cycle the frame is loaded into a 24-bit shift register.
- `send` while `ready` is low is ignored. It is not queued.
- States:
  - IDLE: `spi_csn`=1, `spi_clk`=0, `spi_mosi`=0, `ready`=1. On accept, go to LEAD.
  - LEAD: lasts `CLK_DIV` cycles. `spi_csn`=0, `spi_clk`=0, `spi_mosi`=frame bit 23. Then go to SHIFT.
  - SHIFT: 24 bit periods of `2*CLK_DIV` cycles each. `spi_clk` is high for the first `CLK_DIV` cycles and low for the second `CLK_DIV` cycles. `spi_mosi` advances to the next bit on the same edge where `spi_clk` falls. It is stable across every rising edge. After bit 0's low half, go to TRAIL.
  - TRAIL: lasts `CLK_DIV` cycles with `spi_clk`=0 and `spi_csn`=0. Then go to GAP.
  - GAP: lasts `CSN_IDLE` cycles with `spi_csn`=1, `spi_mosi`=0 and `ready`=0. Then go to IDLE.
- `done` pulses for 1 cycle on the same cycle `spi_csn` first returns high.
- Counters:
  - Bit counter is 5 bits and counts 23 down to 0.
  - Phase counter is 8 bits and reloads to `CLK_DIV-1`.
  - No wrap-around is permitted inside a frame.
- Reset in any state, including mid-frame:
  - Next cycle is IDLE with `spi_csn`=1, `spi_clk`=0, `spi_mosi`=0, `ready`=1 and `done`=0.
  - No partial clock pulse is completed.
  - No GAP is enforced after reset.
- Reset values of all outputs: `spi_csn`=1, `spi_clk`=0, `spi_mosi`=0, `ready`=1, `done`=0.

## Timing

- `spi_csn`, `spi_clk`, `spi_mosi` and `done` are registered outputs. `ready` is decoded from state.
- Accept at edge T: `spi_csn` falls and bit 23 appears at T+1.
- First `spi_clk` rise occurs at T+1+`CLK_DIV`.
- `spi_csn` stays low for exactly `50*CLK_DIV` cycles; `done` is asserted and `spi_csn` rises at T+1+`50*CLK_DIV`.
- `ready` returns high at T+1+`50*CLK_DIV`+`CSN_IDLE`.
- Frame-to-frame period under continuous `send`: `50*CLK_DIV + CSN_IDLE + 1` cycles.

## Configuration

- `GAMEPAD_SPI_TX_AUTO_EN` defined:
  - The block holds a 12-bit `last_sent` register, reset to 12'h000 and updated on every accepted frame.
  - In IDLE, `pad_btn != last_sent` triggers a frame exactly as `send` would, with identical latency.
  - `send` and a change in the same cycle produce one frame.
- `GAMEPAD_SPI_TX_AUTO_EN` undefined: frames start only on `send`. The `last_sent` register and comparator are not built.

## Test plan

- Single frame with `CLK_DIV`=2, `CSN_IDLE`=4, `PAD_INDEX`=1: pulse `send` with `pad_btn`=12'hABC.
  - A receiver model samples 24'hA10ABC on 24 `spi_clk` rising edges.
  - `spi_csn` is low for exactly 100 cycles.
  - `done` is high for 1 cycle, in the same cycle `spi_csn` rises.
- Back-to-back requests: hold `send` high for 2 frames with `pad_btn` = 12'h001 then 12'h800.
  - Two frames, 24'hA10001 and 24'hA10800.
  - `spi_csn` is high for ≥4 cycles between them.
  - `send` during busy does not produce a third frame.
- Input change mid-frame: change `pad_btn` mid-frame. The transmitted bits still match the value captured at accept.
- Reset mid-SHIFT (bit 12, `spi_clk` high): assert `reset` for 1 cycle.
  - Next cycle shows `spi_csn`=1, `spi_clk`=0, `ready`=1.
  - A new `send` on the following cycle produces a full, correct frame.
- `CLK_DIV`=1 stress test: `spi_clk` toggles every cycle, frame `csn`-low length is 50 cycles, and the data is correct.
- With `GAMEPAD_SPI_TX_AUTO_EN`:
  - Step `pad_btn` from 0 to 12'h010 with `send`=0: exactly one frame carrying 24'hA10010.
  - A steady `pad_btn` afterwards produces no further frames.

Source files
------------

// File: rtl/gamepad_spi_tx.sv
// SPI mode-0 master that sends a 24-bit gamepad frame {4'hA, pad, 4'h0, buttons}, MSB first.
// Optional GAMEPAD_SPI_TX_AUTO_EN: also start a frame when pad_btn differs from the last value sent.
module gamepad_spi_tx #(
    parameter int unsigned CLK_DIV   = 4,
    parameter int unsigned CSN_IDLE  = 8,
    parameter int unsigned PAD_INDEX = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [11:0] pad_btn,
    input  logic        send,
    output logic        ready,
    output logic        done,
    output logic        spi_csn,
    output logic        spi_clk,
    output logic        spi_mosi
);

    typedef enum logic [2:0] {
        IDLE,
        LEAD,
        SHIFT,
        TRAIL,
        GAP
    } state_t;

    localparam logic [7:0] PHASE_RELOAD = 8'(CLK_DIV - 1);
    localparam logic [7:0] GAP_RELOAD   = 8'(CSN_IDLE - 1);
    localparam logic [3:0] PAD_ID       = 4'(PAD_INDEX);

    state_t      state_q, state_d;
    logic [7:0]  phase_q, phase_d;
    logic [4:0]  bit_q, bit_d;
    logic        high_q, high_d;
    logic [23:0] shreg_q, shreg_d;
    logic        csn_d, sclk_d, mosi_d, done_d;
    logic        trigger;
    logic        accept;

`ifdef GAMEPAD_SPI_TX_AUTO_EN
    logic [11:0] last_sent;

    always_ff @(posedge clk) begin
        if (reset) begin
            last_sent <= 12'h000;
        end else if (accept) begin
            last_sent <= pad_btn;
        end
    end

    assign trigger = send || (pad_btn != last_sent);
`else
    assign trigger = send;
`endif

    assign ready  = (state_q == IDLE);
    assign accept = trigger && ready;

    // State register; the pins are registered copies of the decoded next state.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            phase_q  <= 8'd0;
            bit_q    <= 5'd0;
            high_q   <= 1'b0;
            shreg_q  <= 24'd0;
            spi_csn  <= 1'b1;
            spi_clk  <= 1'b0;
            spi_mosi <= 1'b0;
            done     <= 1'b0;
        end else begin
            // NOTE: every clocked assignment is non-blocking so all registers see pre-edge values.
            state_q  <= state_d;
            phase_q  <= phase_d;
            bit_q    <= bit_d;
            high_q   <= high_d;
            shreg_q  <= shreg_d;
            spi_csn  <= csn_d;
            spi_clk  <= sclk_d;
            spi_mosi <= mosi_d;
            done     <= done_d;
        end
    end

    always_comb begin
        // NOTE: defaults first so no path through this block can infer a latch.
        state_d = state_q;
        phase_d = phase_q;
        bit_d   = bit_q;
        high_d  = high_q;
        shreg_d = shreg_q;
        unique case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = LEAD;
                    phase_d = PHASE_RELOAD;
                    bit_d   = 5'd23;
                    high_d  = 1'b0;
                    shreg_d = {4'hA, PAD_ID, 4'h0, pad_btn};
                end
            end
            LEAD: begin
                if (phase_q == 8'd0) begin
                    state_d = SHIFT;
                    phase_d = PHASE_RELOAD;
                    high_d  = 1'b1;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            SHIFT: begin
                if (phase_q != 8'd0) begin
                    phase_d = phase_q - 8'd1;
                end else if (high_q) begin
                    // Falling edge of spi_clk: present the next bit.
                    high_d  = 1'b0;
                    phase_d = PHASE_RELOAD;
                    shreg_d = {shreg_q[22:0], 1'b0};
                end else if (bit_q == 5'd0) begin
                    state_d = TRAIL;
                    phase_d = PHASE_RELOAD;
                end else begin
                    bit_d   = bit_q - 5'd1;
                    high_d  = 1'b1;
                    phase_d = PHASE_RELOAD;
                end
            end
            TRAIL: begin
                if (phase_q == 8'd0) begin
                    state_d = GAP;
                    phase_d = GAP_RELOAD;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            GAP: begin
                if (phase_q == 8'd0) begin
                    state_d = IDLE;
                end else begin
                    phase_d = phase_q - 8'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        csn_d  = !(state_d inside {LEAD, SHIFT, TRAIL});
        sclk_d = (state_d == SHIFT) && high_d;
        mosi_d = csn_d ? 1'b0 : shreg_d[23];
        done_d = (state_q == TRAIL) && (state_d == GAP);
    end

endmodule

// File: tb/tb_gamepad_spi_tx.sv
// Directed bench for gamepad_spi_tx: a receiver model samples mosi on spi_clk rises and logs frames.
module tb_gamepad_spi_tx;

    typedef struct {
        logic [23:0] data;
        int          nbits;
        int          low_len;
        int          high_cycles;
        int          fall_cyc;
        logic        done_ok;
    } frame_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        send_a = 1'b0, send_b = 1'b0;
    logic [11:0] pad_a = 12'h000, pad_b = 12'h000;
    logic        ready_a, done_a, csn_a, sclk_a, mosi_a;
    logic        ready_b, done_b, csn_b, sclk_b, mosi_b;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gamepad_spi_tx #(.CLK_DIV(2), .CSN_IDLE(4), .PAD_INDEX(1)) dut_a (
        .clk(clk), .reset(reset), .pad_btn(pad_a), .send(send_a), .ready(ready_a),
        .done(done_a), .spi_csn(csn_a), .spi_clk(sclk_a), .spi_mosi(mosi_a)
    );

    gamepad_spi_tx #(.CLK_DIV(1), .CSN_IDLE(2), .PAD_INDEX(5)) dut_b (
        .clk(clk), .reset(reset), .pad_btn(pad_b), .send(send_b), .ready(ready_b),
        .done(done_b), .spi_csn(csn_b), .spi_clk(sclk_b), .spi_mosi(mosi_b)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Receiver model, one lane per DUT, sampled on the falling clk edge.
    logic        m_csn [2], m_sclk [2], m_mosi [2], m_done [2];
    logic        prev_csn [2] = '{1'b1, 1'b1};
    logic        prev_sclk [2] = '{1'b0, 1'b0};
    logic        aborted [2] = '{1'b1, 1'b1};
    logic [23:0] sh [2];
    int          nb [2], low [2], hi [2], fall [2];
    int          done_cnt [2] = '{0, 0};
    int          pushed [2] = '{0, 0};
    int          cyc = 0;
    frame_t      q0 [$];
    frame_t      q1 [$];

    assign m_csn[0] = csn_a;  assign m_sclk[0] = sclk_a;  assign m_mosi[0] = mosi_a;  assign m_done[0] = done_a;
    assign m_csn[1] = csn_b;  assign m_sclk[1] = sclk_b;  assign m_mosi[1] = mosi_b;  assign m_done[1] = done_b;

    always @(negedge clk) begin
        frame_t f;
        cyc++;
        for (int d = 0; d < 2; d++) begin
            if (reset) begin
                aborted[d] = 1'b1;
                sh[d] = 24'd0; nb[d] = 0; low[d] = 0; hi[d] = 0;
            end else begin
                if (!m_csn[d] && prev_csn[d]) begin
                    aborted[d] = 1'b0;
                    fall[d] = cyc;
                    sh[d] = 24'd0; nb[d] = 0; low[d] = 0; hi[d] = 0;
                end
                if (!m_csn[d]) begin
                    low[d]++;
                    if (m_sclk[d]) hi[d]++;
                    if (m_sclk[d] && !prev_sclk[d]) begin
                        sh[d] = {sh[d][22:0], m_mosi[d]};
                        nb[d]++;
                    end
                end
                if (m_csn[d] && !prev_csn[d]) begin
                    if (aborted[d]) begin
                        check("abort_no_done", {31'd0, m_done[d]}, 32'd0);
                    end else begin
                        f.data = sh[d]; f.nbits = nb[d]; f.low_len = low[d];
                        f.high_cycles = hi[d]; f.fall_cyc = fall[d]; f.done_ok = m_done[d];
                        pushed[d]++;
                        if (d == 0) q0.push_back(f); else q1.push_back(f);
                    end
                end
                if (m_done[d]) done_cnt[d]++;
            end
            prev_csn[d]  = m_csn[d];
            prev_sclk[d] = m_sclk[d];
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_csn_a(input logic val, input string tag);
        int budget = 0;
        while (csn_a !== val && budget < 1000) begin
            tick();
            budget++;
        end
        if (csn_a !== val) check({tag, "_timeout"}, {31'd0, csn_a}, {31'd0, val});
    endtask

    task automatic expect_frame(input int d, input string tag, input logic [23:0] exp_data,
                                input int div, output frame_t f);
        int budget = 0;
        f = '{default: 0};
        while (((d == 0) ? q0.size() : q1.size()) == 0 && budget < 2000) begin
            tick();
            budget++;
        end
        if (((d == 0) ? q0.size() : q1.size()) == 0) begin
            check({tag, "_timeout"}, 32'd0, 32'd1);
            return;
        end
        f = (d == 0) ? q0.pop_front() : q1.pop_front();
        check({tag, "_data"}, {8'd0, f.data}, {8'd0, exp_data});
        check({tag, "_nbits"}, f.nbits, 24);
        check({tag, "_csn_low"}, f.low_len, 50 * div);
        check({tag, "_sclk_high"}, f.high_cycles, 24 * div);
        check({tag, "_done_at_rise"}, {31'd0, f.done_ok}, 32'd1);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        frame_t f1, f2;
        int     n;

        repeat (3) tick();
        reset = 1'b0;
        tick();
        check("rst_csn", {31'd0, csn_a}, 32'd1);
        check("rst_sclk", {31'd0, sclk_a}, 32'd0);
        check("rst_mosi", {31'd0, mosi_a}, 32'd0);
        check("rst_ready", {31'd0, ready_a}, 32'd1);
        check("rst_done", {31'd0, done_a}, 32'd0);
        check("rst_csn_b", {31'd0, csn_b}, 32'd1);

`ifdef GAMEPAD_SPI_TX_AUTO_EN
        repeat (50) tick();
        check("auto_steady_zero", q0.size(), 0);
        pad_a = 12'h010;
        tick();
        check("auto_latency_csn", {31'd0, csn_a}, 32'd0);
        check("auto_latency_mosi", {31'd0, mosi_a}, 32'd1);
        expect_frame(0, "auto", 24'hA10010, 2, f1);
        repeat (400) tick();
        check("auto_no_more", q0.size(), 0);
`else
        // Single frame with latency checks on the LEAD phase.
        pad_a = 12'hABC;
        send_a = 1'b1;
        tick();
        send_a = 1'b0;
        check("lead_csn", {31'd0, csn_a}, 32'd0);
        check("lead_mosi_bit23", {31'd0, mosi_a}, 32'd1);
        check("lead_sclk", {31'd0, sclk_a}, 32'd0);
        check("busy_ready", {31'd0, ready_a}, 32'd0);
        tick();
        check("lead_sclk_2", {31'd0, sclk_a}, 32'd0);
        tick();
        check("first_rise", {31'd0, sclk_a}, 32'd1);
        wait_csn_a(1'b1, "single_end");
        check("done_with_csn", {31'd0, done_a}, 32'd1);
        n = 0;
        while (!ready_a && n < 100) begin
            tick();
            n++;
        end
        check("gap_len", n, 4);
        check("done_one_cycle", {31'd0, done_a}, 32'd0);
        expect_frame(0, "single", 24'hA10ABC, 2, f1);

        // Back-to-back under continuous send; pad changes between accepts.
        pad_a = 12'h001;
        send_a = 1'b1;
        wait_csn_a(1'b0, "b2b_start1");
        pad_a = 12'h800;
        wait_csn_a(1'b1, "b2b_end1");
        wait_csn_a(1'b0, "b2b_start2");
        send_a = 1'b0;
        expect_frame(0, "b2b_1", 24'hA10001, 2, f1);
        expect_frame(0, "b2b_2", 24'hA10800, 2, f2);
        check("b2b_period", f2.fall_cyc - f1.fall_cyc, 105);
        check("b2b_csn_high_ge4", {31'd0, (f2.fall_cyc - f1.fall_cyc - f1.low_len) >= 4}, 32'd1);
        repeat (300) tick();
        check("b2b_no_third", q0.size(), 0);

        // Input change mid-frame.
        pad_a = 12'h5A5;
        send_a = 1'b1;
        tick();
        send_a = 1'b0;
        repeat (30) tick();
        pad_a = 12'hFFF;
        expect_frame(0, "midchg", 24'hA105A5, 2, f1);
        repeat (10) tick();

        // Reset during the high half of bit 12.
        pad_a = 12'hF0F;
        send_a = 1'b1;
        tick();
        send_a = 1'b0;
        n = 0;
        while (!(nb[0] == 12 && sclk_a) && n < 200) begin
            tick();
            n++;
        end
        check("rst_mid_sclk_high", {31'd0, sclk_a}, 32'd1);
        check("rst_mid_bitcnt", nb[0], 12);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("rst_mid_csn", {31'd0, csn_a}, 32'd1);
        check("rst_mid_sclk", {31'd0, sclk_a}, 32'd0);
        check("rst_mid_mosi", {31'd0, mosi_a}, 32'd0);
        check("rst_mid_ready", {31'd0, ready_a}, 32'd1);
        check("rst_mid_done", {31'd0, done_a}, 32'd0);
        pad_a = 12'h3C3;
        send_a = 1'b1;
        tick();
        send_a = 1'b0;
        check("post_rst_accept", {31'd0, csn_a}, 32'd0);
        expect_frame(0, "post_rst", 24'hA103C3, 2, f1);
        check("post_rst_only_one", q0.size(), 0);

        // CLK_DIV = 1 stress on the second instance.
        q1.delete();
        pad_b = 12'h9C6;
        send_b = 1'b1;
        tick();
        send_b = 1'b0;
        check("div1_csn", {31'd0, csn_b}, 32'd0);
        tick();
        check("div1_first_rise", {31'd0, sclk_b}, 32'd1);
        tick();
        check("div1_fall", {31'd0, sclk_b}, 32'd0);
        expect_frame(1, "div1", 24'hA509C6, 1, f1);
`endif

        repeat (20) tick();
        check("done_count_a", done_cnt[0], pushed[0]);
        check("done_count_b", done_cnt[1], pushed[1]);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
